// File: rtl/joy_spi_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : joy_spi_reader_if
//  Purpose  : SPI pin bundle between the joystick poller (master) and the
//             PmodJSTK joystick module (slave).
//  Signals  : ss   - slave select, active-low (master -> slave)
//             sclk - SPI clock, mode 0          (master -> slave)
//             mosi - command/data to joystick   (master -> slave)
//             miso - sample data from joystick  (slave  -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface joy_spi_reader_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss, output sclk, output mosi, input miso);
    modport slave  (input ss, input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/joy_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module   : joy_spi_reader
//  Purpose  : SPI mode-0 master that polls a PmodJSTK joystick once per poll
//             period with a 5-byte transaction and publishes the X/Y samples
//             and button states atomically with a one-cycle sample_valid.
//  Ports    : clk          - system clock
//             clr          - asynchronous active-high reset
//             en           - polling enable
//             leds[1:0]    - LED bits carried in the command byte
//             spi          - SPI pins (joy_spi_reader_if.master)
//             joy_x[9:0]   - latest X sample
//             joy_y[9:0]   - latest Y sample
//             buttons[2:0] - {btn2, btn1, trigger} from latest sample
//             sample_valid - one-cycle pulse when outputs update
//             busy         - high from ss falling through the DONE cycle
//  Options  : JOY_DEADZONE_EN - when defined, axis values within DEADZONE of
//             the centre (512) are published as exactly 512.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_spi_reader #(
    parameter int CLK_DIV      = 50,
    parameter int SS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1500,
    parameter int POLL_CYC     = 1000000,
    parameter int DEADZONE     = 32
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic [1:0]              leds,
    joy_spi_reader_if.master        spi,
    output logic [9:0]              joy_x,
    output logic [9:0]              joy_y,
    output logic [2:0]              buttons,
    output logic                    sample_valid,
    output logic                    busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_hold_a   = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
    localparam int c_hold_max = (c_hold_a > CLK_DIV) ? c_hold_a : CLK_DIV;
    localparam int c_tmr_w    = $clog2(c_hold_max + 1);
    localparam int c_poll_w   = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

    localparam logic [c_tmr_w-1:0]  c_div_last   = c_tmr_w'(CLK_DIV - 1);
    localparam logic [c_tmr_w-1:0]  c_setup_last = c_tmr_w'(SS_SETUP_CYC - 1);
    localparam logic [c_tmr_w-1:0]  c_gap_last   = c_tmr_w'(BYTE_GAP_CYC - 1);
    localparam logic [c_poll_w-1:0] c_poll_last  = c_poll_w'(POLL_CYC - 1);

    localparam logic [9:0] c_centre = 10'd512;
    localparam logic [9:0] c_dz_lo  = 10'(512 - DEADZONE);
    localparam logic [9:0] c_dz_hi  = 10'(512 + DEADZONE);
`ifdef JOY_DEADZONE_EN
    localparam bit c_dz_on = 1'b1;
`else
    localparam bit c_dz_on = 1'b0;
`endif

    // Centre snap applied to an assembled axis value at publish time.
    function automatic logic [9:0] apply_deadzone(input logic [9:0] v);
        if (c_dz_on && (v >= c_dz_lo) && (v <= c_dz_hi))
            return c_centre;
        return v;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_BYTE_GAP = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_poll_w-1:0] r_poll;
    logic [c_tmr_w-1:0]  r_tmr;     // hold / half-period timer
    logic [2:0]          r_bit;     // rising edges seen in the current byte, minus one
    logic [2:0]          r_idx;     // byte index 0..4
    logic [6:0]          r_tx;      // tx bits still to be driven after the current one
    logic [7:0]          r_rx_sr;   // rx shift register, MSB first
    logic [7:0]          r_rx0;
    logic [1:0]          r_rx1;
    logic [7:0]          r_rx2;
    logic [1:0]          r_rx3;
    logic                r_ss;
    logic                r_sclk;
    logic                r_mosi;

    logic                w_wrap;
    logic                w_start;
    logic [7:0]          w_cmd;

    assign w_wrap  = (r_poll == c_poll_last);
    assign w_start = w_wrap && (r_state == S_IDLE) && en;
    assign w_cmd   = {6'b100000, leds};

    assign spi.ss   = r_ss;
    assign spi.sclk = r_sclk;
    assign spi.mosi = r_mosi;

    // ------------------------------------------------------------------------
    // Free-running poll counter; a wrap that is not taken is simply lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_poll <= '0;
        else if (w_wrap)
            r_poll <= '0;
        else
            r_poll <= r_poll + 1'b1;
    end

    // ------------------------------------------------------------------------
    // Transaction FSM. The first rising SCLK edge of each byte is issued by the
    // SS_SETUP / BYTE_GAP states as they hand over to SHIFT, so SHIFT only ever
    // sees half-period expiries.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_bit        <= '0;
            r_idx        <= '0;
            r_tx         <= '0;
            r_rx_sr      <= '0;
            r_rx0        <= '0;
            r_rx1        <= '0;
            r_rx2        <= '0;
            r_rx3        <= '0;
            r_ss         <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            joy_x        <= c_centre;
            joy_y        <= c_centre;
            buttons      <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ss   <= 1'b1;
                    r_sclk <= 1'b0;
                    if (w_start) begin
                        r_ss    <= 1'b0;
                        r_mosi  <= w_cmd[7];
                        r_tx    <= w_cmd[6:0];
                        r_idx   <= '0;
                        r_tmr   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SS_SETUP;
                    end
                end

                S_SS_SETUP: begin
                    if (r_tmr == c_setup_last) begin
                        r_tmr   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx_sr <= {r_rx_sr[6:0], spi.miso};
                        r_state <= S_SHIFT;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_tmr != c_div_last) begin
                        r_tmr <= r_tmr + 1'b1;
                    end else begin
                        r_tmr <= '0;
                        if (r_sclk) begin
                            // Falling edge: present the next tx bit.
                            r_sclk <= 1'b0;
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[5:0], 1'b0};
                        end else if (r_bit != 3'd7) begin
                            // Rising edge: sample miso.
                            r_sclk  <= 1'b1;
                            r_rx_sr <= {r_rx_sr[6:0], spi.miso};
                            r_bit   <= r_bit + 1'b1;
                        end else begin
                            // Trailing low half-period finished: byte complete.
                            case (r_idx)
                                3'd0:    r_rx0 <= r_rx_sr;
                                3'd1:    r_rx1 <= r_rx_sr[1:0];
                                3'd2:    r_rx2 <= r_rx_sr;
                                3'd3:    r_rx3 <= r_rx_sr[1:0];
                                default: ;
                            endcase
                            if (r_idx != 3'd4) begin
                                r_idx   <= r_idx + 1'b1;
                                r_tx    <= '0;
                                r_mosi  <= 1'b0;   // bit 7 of a filler byte
                                r_state <= S_BYTE_GAP;
                            end else begin
                                // Byte 4 is still in the shift register.
                                r_ss         <= 1'b1;
                                joy_x        <= apply_deadzone({r_rx1, r_rx0});
                                joy_y        <= apply_deadzone({r_rx3, r_rx2});
                                buttons      <= r_rx_sr[2:0];
                                sample_valid <= 1'b1;
                                r_state      <= S_DONE;
                            end
                        end
                    end
                end

                S_BYTE_GAP: begin
                    if (r_tmr == c_gap_last) begin
                        r_tmr   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx_sr <= {r_rx_sr[6:0], spi.miso};
                        r_state <= S_SHIFT;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/joy_spi_reader.md
Name: joy_spi_reader

Overview:
- SPI master that polls the PmodJSTK joystick module.
- Produces the 10-bit joy_x / joy_y samples and the button states consumed by the cursor-update logic.
- Runs one 5-byte SPI transaction per poll period and publishes each result atomically with a one-cycle sample_valid strobe.
- Sits between the top-level Pmod pins and the cursor/dot update blocks.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period (100 MHz clk -> 1 MHz SCLK).
- SS_SETUP_CYC, 1500: clk cycles from ss falling to the start of byte 0 (15 us).
- BYTE_GAP_CYC, 1500: clk cycles of idle SCLK between bytes (15 us).
- POLL_CYC, 1000000: poll period in clk cycles (10 ms); must exceed one full transaction length.
- DEADZONE, 32: half-width of the centre snap window; used only with JOY_DEADZONE_EN.

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- en  in  1  polling enable
- leds  in  2  LED bits sent in the command byte
- miso  in  1  SPI data from joystick
- ss  out  1  SPI slave select, active-low
- sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- mosi  out  1  SPI data to joystick
- joy_x  out  10  latest X sample
- joy_y  out  10  latest Y sample
- buttons  out  3  {btn2, btn1, trigger} from latest sample
- sample_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  high from ss falling until the DONE cycle inclusive

Behaviour:
- Reset values (asynchronous on clr): ss=1, sclk=0, mosi=0, joy_x=512, joy_y=512, buttons=0, sample_valid=0, busy=0. Poll counter=0, state=IDLE.
  - Centred reset values keep the dot stationary after reset.
- Poll counter: free-running 0..POLL_CYC-1. At wrap, if state==IDLE and en==1, start a transaction. A wrap while busy or with en==0 is dropped, not queued.
- States:
  - IDLE: ss=1, sclk=0. On start, latch cmd = {6'b100000, leds}, byte index=0, go to SS_SETUP.
  - SS_SETUP: ss=0, mosi=cmd[7]. Hold SS_SETUP_CYC cycles, then go to SHIFT.
  - SHIFT: 8 bits, MSB first. Each half-period is CLK_DIV cycles.
    - sclk 0->1: sample miso into the shift register LSB.
    - sclk 1->0: drive the next tx bit on mosi.
    - After the 8th rising edge plus one more low half-period (sclk=0), the byte is complete: store rx byte[index].
    - If index<4: index+1, go to BYTE_GAP. Else go to DONE.
  - BYTE_GAP: sclk=0, ss=0, mosi=next byte bit7. Hold BYTE_GAP_CYC cycles, then go to SHIFT.
  - DONE: ss=1 and all outputs update in this single cycle, then go to IDLE.
    - joy_x={rx1[1:0],rx0}
    - joy_y={rx3[1:0],rx2}
    - buttons=rx4[2:0]
    - sample_valid=1
- Tx bytes: byte 0 is cmd; bytes 1-4 are 8'h00.
- Rx bits rx1[7:2], rx3[7:2] and rx4[7:3] are ignored.
- joy_x, joy_y and buttons never change except in the DONE cycle; there are no partial updates.
- en falling mid-transaction: the transaction completes normally; no further starts.
- leds changing mid-transaction: no effect until the next start.
- clr mid-transaction: immediate abort to reset values; ss rises asynchronously with clr.
- No glitches on sclk or ss; both are registered outputs.

Optional Feature:
- Macro: JOY_DEADZONE_EN.
- Defined: in the DONE cycle, each axis value v with 512-DEADZONE <= v <= 512+DEADZONE is published as exactly 512. Values outside the window pass unchanged. Buttons are unaffected.
- Undefined: raw assembled values are published; the DEADZONE parameter is unused.

Test Plan (bench uses CLK_DIV=2, SS_SETUP_CYC=8, BYTE_GAP_CYC=6, POLL_CYC=400 and a mode-0 slave model):
- Basic read: slave returns 0x34,0x02,0xC8,0x01,0x05 -> joy_x=564, joy_y=456, buttons=3'b101, exactly one sample_valid pulse, ss high again after DONE.
- Command byte and masking: leds=2'b11 and slave byte 1=0xFE -> first 8 mosi bits are 0x83, bytes 1-4 are 0x00, joy_x upper bits=2'b10 (upper 6 bits of 0xFE ignored).
- Timing: ss fall to first sclk rise = 8 clk; gap between the last falling edge of one byte and the first rising edge of the next ≥ 6+2 clk; 40 sclk rising edges per transaction; one transaction per 400 clk.
- Enable: en=0 for 2000 clk -> ss stays 1, no sample_valid. en dropped mid-transaction -> that transaction completes, then no more.
- Reset mid-SHIFT: assert clr during byte 2 -> ss=1, sclk=0, joy_x=joy_y=512 immediately; after release the first transaction gives correct fresh values.
- Deadzone (JOY_DEADZONE_EN, DEADZONE=32): X raw 540 -> 512; X raw 545 -> 545; Y raw 480 -> 512; Y raw 479 -> 479.
